// File: rtl/fsquare.sv
// fsquare: two-stage pipelined IEEE-754 binary32 squarer, dest = src * src.
// Stage 1 classifies the operand and forms the 48-bit mantissa product.
// Stage 2 normalises, rounds to nearest-even, packs the result and holds it
// until the consumer accepts it. The stages stall independently, so an empty
// stage 1 still accepts input while the output is stalled.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   src        binary32 operand
//   in_valid   src is valid this cycle
//   in_ready   block can accept src this cycle
//   dest       binary32 result (always non-negative, or canonical NaN)
//   out_valid  dest is valid
//   out_ready  consumer accepts dest this cycle
module fsquare #(
  parameter logic [31:0] NAN_OUT = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] dest,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    K_NORM = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_t;

  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] POS_ZERO = 32'h00000000;

  logic               en1;
  logic               en2;

  logic               s1_valid;
  kind_t              s1_kind;
  logic [47:0]        s1_p;
  logic signed [9:0]  s1_e2;

  logic [7:0]         src_exp;
  logic [22:0]        src_frac;
  logic [23:0]        src_m;
  kind_t              src_kind;
  logic [47:0]        src_p;
  logic signed [9:0]  src_e2;

  // The sign never affects a square, so src[31] is deliberately dropped.
  logic               unused_sign;

  logic [22:0]        mant_n;
  logic               g;
  logic               st;
  logic signed [9:0]  e_n;
  logic               up;
  logic [23:0]        mant_r;
  logic signed [9:0]  e_r;
  logic [31:0]        result;

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  assign unused_sign = src[31];
  assign src_exp     = src[30:23];
  assign src_frac    = src[22:0];
  assign src_m       = {1'b1, src_frac};
  assign src_p       = 48'(src_m) * 48'(src_m);
  // 2*exp - 127 spans -125..381, so 10 signed bits hold it with headroom for +2.
  assign src_e2      = $signed({1'b0, src_exp, 1'b0}) - 10'sd127;

  always_comb begin
    src_kind = K_NORM;
    if (src_exp == 8'd0)
      src_kind = K_ZERO;
    else if (src_exp == 8'hFF)
      src_kind = (src_frac == 23'd0) ? K_INF : K_NAN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_kind  <= K_ZERO;
      s1_p     <= 48'd0;
      s1_e2    <= 10'sd0;
    end else if (en1) begin
      s1_valid <= in_valid;
      s1_kind  <= src_kind;
      s1_p     <= src_p;
      s1_e2    <= src_e2;
    end
  end

  // Product of two values in [1,2) lies in [1,4): one optional right shift.
  always_comb begin
    if (s1_p[47]) begin
      mant_n = s1_p[46:24];
      g      = s1_p[23];
      st     = |s1_p[22:0];
      e_n    = s1_e2 + 10'sd1;
    end else begin
      mant_n = s1_p[45:23];
      g      = s1_p[22];
      st     = |s1_p[21:0];
      e_n    = s1_e2;
    end
  end

  assign up     = g & (st | mant_n[0]);
  assign mant_r = {1'b0, mant_n} + 24'(up);
  // A rounding carry out of the fraction means the significand became 2.0.
  assign e_r    = mant_r[23] ? (e_n + 10'sd1) : e_n;

  always_comb begin
    result = POS_ZERO;
    case (s1_kind)
      K_ZERO: result = POS_ZERO;
      K_INF:  result = POS_INF;
      K_NAN:  result = NAN_OUT;
      default: begin
        if (e_r >= 10'sd255)
          result = POS_INF;
        else if (e_r <= 10'sd0)
          result = POS_ZERO;
        else
          result = {1'b0, e_r[7:0], mant_r[22:0]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dest      <= 32'h0;
    end else if (en2) begin
      out_valid <= s1_valid;
      dest      <= result;
    end
  end

endmodule

// File: tb/tb_fsquare.sv
// tb_fsquare: self-checking bench for fsquare. Directed cases cover latency,
// rounding, range limits, specials, backpressure and reset; a randomized phase
// with random valid/ready traffic is scored against an arithmetic reference.
module tb_fsquare;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dest;
  logic        out_valid;
  logic        out_ready;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  logic [31:0] sb[$];

  fsquare dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dest      (dest),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact square as an integer significand times a power of two, rounded to
  // 24 significant bits (nearest-even), then flushed/saturated to binary32.
  function automatic logic [31:0] ref_square(input logic [31:0] x);
    int     ex;
    int     n;
    int     sh;
    int     e;
    longint m;
    longint p;
    longint q;
    longint rem;
    longint half;
    ex = int'(x[30:23]);
    if (ex == 255) return (x[22:0] != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
    if (ex == 0) return 32'h0;
    m = longint'({1'b1, x[22:0]});
    p = m * m;
    n = 0;
    for (int i = 0; i < 60; i++)
      if (p >= (longint'(1) << i)) n = i;
    sh   = n - 23;
    q    = p >>> sh;
    rem  = p - (q <<< sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    // value = p * 2^(2*ex-300); unbiased exponent of its leading bit is n+2*ex-300
    e = n + 2 * ex - 300 + 127;
    if (q == (longint'(1) << 24)) begin
      q = q >>> 1;
      e++;
    end
    if (e >= 255) return 32'h7F800000;
    if (e <= 0) return 32'h0;
    return {1'b0, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [8];
    logic [31:0] r;
    specials = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h807FFFFF,
                 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'hFFFFFFFF};
    if ($urandom_range(0, 15) == 0) begin
      r = specials[$urandom_range(0, 7)];
    end else begin
      r[31]    = 1'($urandom_range(0, 1));
      r[30:23] = 8'($urandom_range(1, 254));
      r[22:0]  = 23'($urandom());
    end
    return r;
  endfunction

  // Scoreboard: every accepted input enqueues its expected square; every
  // accepted output must match the oldest entry.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(ref_square(src));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0)
          chk("sb_unexpected_out", 32'd1, 32'd0);
        else
          chk("sb_dest", dest, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] s, input logic [31:0] exp);
    out_ready = 1'b1;
    src       = s;
    in_valid  = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    src      = 32'hDEADBEEF;
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_dest"}, dest, exp);
    tick();
  endtask

  logic [31:0] d_src [12];
  logic [31:0] d_exp [12];

  initial begin
    int cyc;
    d_src = '{32'h40400000, 32'hC0000000, 32'h3FC00000, 32'h3F800001,
              32'h7F000000, 32'h1F800000, 32'h00000001, 32'hFF800000,
              32'h7FC00001, 32'h3F800000, 32'h80000000, 32'h3F3504F3};
    d_exp = '{32'h41100000, 32'h40800000, 32'h40100000, 32'h3F800002,
              32'h7F800000, 32'h00000000, 32'h00000000, 32'h7F800000,
              32'h7FC00000, 32'h3F800000, 32'h00000000, 32'h3EFFFFFF};

    rst       = 1'b1;
    src       = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dest", dest, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++)
      run_one($sformatf("dir%0d", i), d_src[i], d_exp[i]);

    // Backpressure: 3.0 and 1.5 fill both stages, 2.0 must be refused.
    out_ready = 1'b0;
    src       = 32'h40400000;
    in_valid  = 1'b1;
    tick();
    src = 32'h3FC00000;
    tick();
    src = 32'h40000000;
    #1;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_dest", dest, 32'h41100000);
    tick();
    chk("bp_hold_dest2", dest, 32'h41100000);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_out0", dest, 32'h41100000);
    tick();
    in_valid = 1'b0;
    chk("bp_out1_valid", 32'(out_valid), 32'd1);
    chk("bp_out1", dest, 32'h40100000);
    tick();
    chk("bp_out2_valid", 32'(out_valid), 32'd1);
    chk("bp_out2", dest, 32'h40800000);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    src       = 32'h40400000;
    in_valid  = 1'b1;
    tick();
    src = 32'h3FC00000;
    tick();
    in_valid = 1'b0;
    chk("rm_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_dest", dest, 32'h0);
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_no_ghost", 32'(out_valid), 32'd0);
    end

    // Random traffic with random stalls on both sides.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 3000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      src       = rand_operand();
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_accepted", 32'(n_acc >= 3000), 32'd1);
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("rand_drain_left", 32'(sb.size()), 32'd0);
    tick();
    chk("rand_idle_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
